// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state/mode types and width helper for the FIFO burst reader
package fifo_reader_pkg;
  typedef enum logic {IDLE, BURST} rd_state_t;
  typedef enum logic {FULL, SHORT} burst_mode_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops an FWFT FIFO in full or short bursts onto a registered valid/ready stream with last
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic                  fifo_almost_full,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_pop,
  input  logic                  flush_req,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);
  localparam int BW = cnt_w(BURST_LEN);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TIME_MAX = TW'(TIMEOUT_CYCLES - 1);
  rd_state_t state_q, state_d;
  burst_mode_t mode_q, mode_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] beat_q, beat_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic can_load, last_beat, start_full, start_short;
  always_comb begin
    can_load    = !m_valid_q || m_ready;
    fifo_pop    = !rst && state_q == BURST && !fifo_empty && can_load;
    last_beat   = beat_q == BEAT_MAX || (mode_q == SHORT && fifo_almost_empty);
    start_full  = state_q == IDLE && fifo_almost_full;
    start_short = state_q == IDLE && !fifo_almost_full && !fifo_empty && (timer_q == TIME_MAX || flush_req);
    state_d     = state_q;
    mode_d      = mode_q;
    beat_d      = beat_q;
    timer_d     = state_q == BURST || fifo_empty || fifo_almost_full ? '0
                : timer_q == TIME_MAX ? timer_q : timer_q + 1'b1;
    if (start_full || start_short) begin
      state_d = BURST;
      mode_d  = start_full ? FULL : SHORT;
      beat_d  = '0;
      timer_d = '0;
    end else if (fifo_pop) begin
      beat_d  = beat_q + 1'b1;
      state_d = last_beat ? IDLE : BURST;
    end
    m_data_d  = fifo_pop ? fifo_rd_data : m_data_q;
    m_valid_d = fifo_pop ? 1'b1 : m_valid_q && !m_ready;
    m_last_d  = fifo_pop ? last_beat : m_last_q && !m_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= FULL;
      timer_q   <= '0;
      beat_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      timer_q   <= timer_d;
      beat_q    <= beat_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = state_q == BURST || m_valid_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and randomized checks of the burst reader behind a behavioural FWFT FIFO
module tb_fifo_burst_reader;
  import fifo_reader_pkg::*;
  logic clk = 1'b0;
  logic rst, push, flush_req, m_ready, rnd_ready;
  logic [7:0] pd;
  logic fifo_empty, fifo_almost_empty, fifo_almost_full, fifo_pop;
  logic [7:0] fifo_rd_data, m_data;
  logic m_valid, m_last, busy;
  int n_cmp = 0, n_bad = 0, n_beats = 0;
  logic [7:0] exp_d[$];
  logic exp_l[$];
  logic [7:0] mem[16];
  int wp, rp, cnt;
  logic st_q;
  logic [7:0] st_d;
  logic st_l;
  always #5 clk = ~clk;
  fifo_burst_reader dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_rd_data(fifo_rd_data), .fifo_pop(fifo_pop),
    .flush_req(flush_req), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy)
  );
  assign fifo_empty        = cnt == 0;
  assign fifo_almost_empty = cnt <= 1;
  assign fifo_almost_full  = cnt >= 4;
  assign fifo_rd_data      = mem[rp];
  always @(posedge clk) begin
    if (rst) begin
      wp  <= 0;
      rp  <= 0;
      cnt <= 0;
    end else begin
      if (push) mem[wp] <= pd;
      wp  <= push ? (wp + 1) % 16 : wp;
      rp  <= fifo_pop ? (rp + 1) % 16 : rp;
      cnt <= cnt + (push ? 1 : 0) - (fifo_pop ? 1 : 0);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (rst) st_q = 1'b0;
    else begin
      if (st_q) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(st_d));
        chk("stall_last", 32'(m_last), 32'(st_l));
      end
      if (m_valid && !m_ready) chk("stall_nopop", 32'(fifo_pop), 32'd0);
      if (m_valid && m_ready) begin
        n_beats++;
        if (exp_d.size() == 0) chk("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
        else begin
          chk("beat_data", 32'(m_data), 32'(exp_d.pop_front()));
          chk("beat_last", 32'(m_last), 32'(exp_l.pop_front()));
        end
      end
      st_q = m_valid && !m_ready;
      st_d = m_data;
      st_l = m_last;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) m_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic push_word(input logic [7:0] d);
    push = 1'b1;
    pd   = d;
    step();
    push = 1'b0;
  endtask
  task automatic expect_beat(input logic [7:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask
  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_d.size() != 0; i++) step();
    chk(tag, 32'(exp_d.size()), 32'd0);
    for (int i = 0; i < 40 && busy; i++) step();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    step();
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int i, k;
    logic [7:0] d;
    logic pat[7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; push = 1'b0; pd = '0; flush_req = 1'b0; m_ready = 1'b1; rnd_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
    for (int j = 0; j < 4; j++) begin
      expect_beat(8'hA0 + 8'(j), j == 3);
      push_word(8'hA0 + 8'(j));
    end
    chk("full_start_nopop", 32'(fifo_pop), 32'd0);
    step();
    chk("full_first_pop", 32'(fifo_pop), 32'd1);
    chk("full_no_valid_yet", 32'(m_valid), 32'd0);
    step();
    chk("full_first_valid", 32'(m_valid), 32'd1);
    chk("full_first_data", 32'(m_data), 32'hA0);
    repeat (3) step();
    chk("full_last_flag", 32'(m_last), 32'd1);
    chk("full_last_data", 32'(m_data), 32'hA3);
    chk("full_busy_last", 32'(busy), 32'd1);
    chk("full_idle_gap", 32'(dut.state_q), 32'(IDLE));
    step();
    chk("full_busy_fall", 32'(busy), 32'd0);
    chk("full_fifo_empty", 32'(fifo_empty), 32'd1);
    wait_drain("full_drain", 5);
    for (int j = 0; j < 6; j++) begin
      expect_beat(8'h10 + 8'(j), j == 3 || j == 5);
      push_word(8'h10 + 8'(j));
    end
    for (i = 0; i < 40 && exp_d.size() > 2; i++) step();
    chk("fs_full_done", 32'(exp_d.size()), 32'd2);
    repeat (12) step();
    chk("fs_short_not_early", 32'(exp_d.size()), 32'd2);
    wait_drain("fs_drain", 40);
    for (int j = 0; j < 4; j++) begin
      expect_beat(8'hC0 + 8'(j), j == 3);
      push_word(8'hC0 + 8'(j));
    end
    for (i = 0; i < 10 && !m_valid; i++) step();
    chk("bp_valid_seen", 32'(m_valid), 32'd1);
    for (int j = 0; j < 7; j++) begin
      m_ready = pat[j];
      step();
    end
    m_ready = 1'b1;
    wait_drain("bp_drain", 20);
    expect_beat(8'h5A, 1'b1);
    push_word(8'h5A);
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    wait_drain("flush_drain", 6);
    k = n_beats;
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (20) step();
    chk("flush_empty_nobeat", 32'(n_beats - k), 32'd0);
    chk("flush_empty_busy", 32'(busy), 32'd0);
    expect_beat(8'h33, 1'b1);
    expect_beat(8'h77, 1'b1);
    push_word(8'h33);
    for (i = 0; i < 30 && !fifo_pop; i++) step();
    chk("cp_pop_seen", 32'(fifo_pop), 32'd1);
    chk("cp_timeout_latency", 32'(i), 32'd16);
    push = 1'b1;
    pd = 8'h77;
    step();
    push = 1'b0;
    wait_drain("cp_drain", 60);
    expect_beat(8'hB0, 1'b0);
    expect_beat(8'hB1, 1'b0);
    for (int j = 0; j < 4; j++) push_word(8'hB0 + 8'(j));
    repeat (4) step();
    chk("mid_valid_before_rst", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pop", 32'(fifo_pop), 32'd0);
    step();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("mid_rst_timer", 32'(dut.timer_q), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_pop", 32'(fifo_pop), 32'd0);
    step();
    chk("mid_after_valid", 32'(m_valid), 32'd0);
    chk("mid_after_pop", 32'(fifo_pop), 32'd0);
    chk("mid_after_fifo", 32'(fifo_empty), 32'd1);
    chk("mid_beats_done", 32'(exp_d.size()), 32'd0);
    exp_d.delete();
    exp_l.delete();
    step();
    rnd_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(1, 7);
      for (int j = 0; j < k; j++) begin
        d = 8'($urandom);
        expect_beat(d, k < 4 ? j == k - 1 : (j == 3 || j == k - 1));
        push_word(d);
      end
      wait_drain("rnd_drain", 150);
    end
    rnd_ready = 1'b0;
    m_ready = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side companion to the team's FWFT FIFO. It watches the FIFO status flags, pops entries in bursts, and presents them on a registered valid/ready stream with a last marker.
- A full burst (BURST_LEN beats) is drained when enough entries are buffered.
- A short burst is drained on idle timeout or on an explicit flush request.
- Sits between a producer-side FIFO and a burst-oriented consumer (bus master, packetiser).

Parameters:
- DATA_WIDTH, 8, width of FIFO entries and of m_data.
- BURST_LEN, 4, maximum beats per burst; legal range is at least 1 and no more than FIFO depth - 1.
- TIMEOUT_CYCLES, 16, number of idle cycles with a non-empty, below-threshold FIFO before a short burst is forced; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_almost_empty  in  1  FIFO almost-empty flag; high when the FIFO holds 1 entry or fewer.
- fifo_almost_full  in  1  FIFO almost-full flag; high when the FIFO holds BURST_LEN entries or more.
- fifo_rd_data  in  DATA_WIDTH  FWFT head of the FIFO.
- fifo_pop  out  1  pop strobe, combinational.
- flush_req  in  1  single-cycle request to drain a short burst.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output beat data.
- m_last  out  1  final beat of the current burst.
- busy  out  1  high while in BURST state or while m_valid is high.

Behaviour:
- Integration requirement:
  - The FIFO instance uses ALMOST_FULL_THRESHOLD = BURST_LEN and ALMOST_EMPTY_THRESHOLD = 1.
  - The FIFO is reset together with this block.
- Reset values: state IDLE, mode FULL, m_valid 0, m_last 0, m_data 0, timer 0, beat_cnt 0. fifo_pop is forced to 0 in any cycle where rst is high.
- Flags are registered versions of the FIFO's next count, so in any cycle they reflect the current FIFO occupancy.
- IDLE state:
  - Timer: cleared to 0 when fifo_empty is high or fifo_almost_full is high. Otherwise it increments, saturating at TIMEOUT_CYCLES-1.
  - Start conditions are evaluated in priority order:
    1. fifo_almost_full high: enter BURST with mode FULL.
    2. fifo_empty low and (timer == TIMEOUT_CYCLES-1 or flush_req high): enter BURST with mode SHORT.
  - flush_req with an empty FIFO is dropped.
  - On entry to BURST: beat_cnt <= 0 and timer <= 0.
  - No pop occurs in IDLE.
- BURST state:
  - can_load = !m_valid or m_ready.
  - fifo_pop = BURST and !fifo_empty and can_load.
  - On a pop:
    - m_data <= fifo_rd_data and m_valid <= 1.
    - m_last <= (beat_cnt == BURST_LEN-1) or (mode == SHORT and fifo_almost_empty).
    - beat_cnt increments.
  - If the beat just popped is last, the next state is IDLE.
  - In FULL mode the FIFO cannot empty mid-burst, because this block is the only popper.
  - In SHORT mode, a concurrent upstream push does not extend the burst; the extra entries go in a later burst.
- Output register:
  - If there is no pop and m_valid && m_ready, then m_valid <= 0 and m_last <= 0.
  - m_data and m_last are held stable while m_valid && !m_ready.
- Latency: with m_ready held high, the start condition in cycle N gives the first pop in N+1 and m_valid in N+2. After that, one beat per cycle with no bubbles inside a burst. There is at least one IDLE cycle between bursts.
- flush_req received during BURST is ignored and not queued.
- BURST_LEN = 1: every beat has m_last high.
- Width rules:
  - beat_cnt width is $clog2(BURST_LEN) with a minimum of 1.
  - timer width is $clog2(TIMEOUT_CYCLES) with a minimum of 1.
  - All comparisons are unsigned.
- Reset mid-burst: the next cycle shows IDLE and m_valid 0. Beats already popped but not yet accepted are discarded.

Decomposition:
- fifo_reader_pkg:
  - rd_state_t enum {IDLE, BURST}.
  - burst_mode_t enum {FULL, SHORT}.
- No sub-module. The bench instantiates the team FIFO (ADDR_WIDTH 4) in front of the DUT.

Test Plan:
- Full burst: push 4 words 0xA0..0xA3, m_ready=1. Expect 4 consecutive beats 0xA0..0xA3, m_last only on 0xA3, FIFO empty afterwards, busy falls one cycle after the last handshake.
- Full then short: push 6 words 0x10..0x15. Expect a FULL burst 0x10..0x13 with last on 0x13. Then, TIMEOUT_CYCLES(16)+1 cycles after the FIFO drops below the threshold, expect a SHORT burst 0x14,0x15 with last on 0x15.
- Backpressure: 4-word burst with m_ready toggling 1,0,0,1,0,1,1. Expect m_data/m_last stable while stalled, no pop while m_valid && !m_ready, all 4 beats delivered in order.
- Flush: push 1 word 0x5A, pulse flush_req 2 cycles later. Expect a SHORT burst of a single beat 0x5A with m_last=1, well before timeout. flush_req with an empty FIFO gives no beat.
- Concurrent push in short mode: 1 entry present at timeout, push 0x77 in the same cycle as the pop. Expect a 1-beat burst with last=1, then 0x77 emitted in a later burst.
- Reset mid-burst: assert rst after beat 2 of 4. Expect m_valid=0 and fifo_pop=0 during reset and the cycle after, IDLE state, timer 0.
